id_scoreboard: RTL and testbench
================================

ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, operand data width.
REQ-002 Parameter AW, default 5, register address width; NREG = 2^AW registers.
REQ-003 Parameter NRD, default 2, number of operand read ports.
REQ-004 Parameter NFWD, default 3, number of forwarding sources; index 0 is the youngest and has the highest priority.
REQ-005 Parameter LW, default 3, latency field width. TW, default 3, tag width.
REQ-006 One clock; reset is synchronous and active-high. Ports: clk, rst.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 flush  in  1  discard all in-flight producers.
REQ-010 iss_valid  in  1  the instruction in ID leaves ID this cycle.
REQ-011 iss_we, iss_waddr[AW], iss_lat[LW]  in  issuing instruction's write enable, destination, and cycles until its result is forwardable.
REQ-012 iss_tag  out  TW  tag assigned to the issuing instruction.
REQ-013 rd_addr  in  NRD*AW; rf_rdata  in  NRD*DATA_W; rd_data  out  NRD*DATA_W; port i occupies slice i.
REQ-014 fwd_valid[NFWD], fwd_addr[NFWD*AW], fwd_data[NFWD*DATA_W]  in  forwarding sources (EX, MEM, ...).
REQ-015 wb_valid, wb_waddr[AW], wb_tag[TW], wb_data[DATA_W]  in  retiring write.
REQ-016 stallreq  out  1  ID must hold.
REQ-017 err  out  1  sticky: a busy, ready operand had no data source.

Function
REQ-018 State per register r: busy[r], cnt[r] (LW bits), tag[r] (TW bits). Plus a tag counter tctr (TW bits).
REQ-019 Register 0 is never busy. A read of address 0 returns 0 and never stalls.
REQ-020 Port i stalls when busy[a] && cnt[a]!=0, with a = rd_addr[i] != 0. stallreq is the combinational OR over all ports.
REQ-021 An issue is accepted when iss_valid && !stallreq && !flush. When stallreq=1, iss_valid causes no state change.
REQ-022 On an accepted issue with iss_we && iss_waddr!=0: busy, cnt and tag of that register load 1, iss_lat and tctr at the next edge; tctr then increments, wrapping at 2^TW.
REQ-023 iss_tag = tctr (combinational).
REQ-024 Every non-issued busy register with cnt!=0 decrements cnt by 1 per cycle. cnt saturates at 0.
REQ-025 iss_lat=0 means the result is forwardable in the next cycle.
REQ-026 Retire: wb_valid && busy[wb_waddr] && tag[wb_waddr]==wb_tag clears busy and cnt. If the tag mismatches, there is no effect (WAW safety).
REQ-027 If a retire and an accepted issue hit the same register in the same cycle, the issue wins.
REQ-028 rd_data[i] selection, in priority order:
  - 0 when a==0;
  - else fwd_data[j] for the lowest j with fwd_valid[j] && fwd_addr[j]==a;
  - else wb_data if wb_valid && wb_waddr==a;
  - else rf_rdata[i].
REQ-029 err is set at the next edge when a port has busy[a] && cnt[a]==0 but no fwd/wb match. err clears only on rst.
REQ-030 flush clears all busy and cnt at the next edge. tctr is kept. flush overrides a same-cycle issue and retire.
REQ-031 Port results are independent. All ports may read the same address.

Reset
REQ-032 rst clears busy, cnt, tctr and err at the next edge. It overrides flush, issue and retire.
REQ-033 After reset: stallreq=0, iss_tag=0, err=0, and rd_data follows the bypass/rf_rdata mux.
REQ-034 rst asserted mid-operation discards all in-flight state within one cycle.

Verification
REQ-035 Issue r5 with lat=0, tag 0, then the next cycle read r5 with fwd_valid[0]=1, addr 5, data 0xAAAA -> stallreq=0, rd_data=0xAAAA, err=0.
REQ-036 Issue r7 with lat=2 (load), then read r7 -> stallreq=1 for 2 cycles, 0 on the 3rd; a held iss_valid during the stall leaves tctr=1.
REQ-037 Issue r3 (tag 0), then r3 again (tag 1), then WB r3 with tag 0 -> busy[3] stays 1; WB r3 with tag 1 -> busy[3] clears.
REQ-038 Two matching sources for r9, fwd_data[0]=0x11 and fwd_data[1]=0x22, with wb r9=0x33 -> rd_data=0x11. Drop source 0 -> 0x22. Drop source 1 -> 0x33.
REQ-039 Busy r4 with lat=6, then flush -> the next cycle read r4 gives stallreq=0; tctr is unchanged.
REQ-040 Issue to r0 -> no busy and tctr unchanged; read r0 -> rd_data=0. Busy r2 ready with no source -> err=1 sticky until rst.

Source files
------------

// File: rtl/id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : id_scoreboard
// Purpose  : Decode-stage register scoreboard with latency countdown, tagged
//            retirement, operand bypass mux and sticky missing-source error.
// Revision : 1.0 - initial release
// ============================================================================
module id_scoreboard #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int NFWD   = 3,
    parameter int LW     = 3,
    parameter int TW     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   iss_valid,
    input  logic                   iss_we,
    input  logic [AW-1:0]          iss_waddr,
    input  logic [LW-1:0]          iss_lat,
    output logic [TW-1:0]          iss_tag,
    input  logic [NRD*AW-1:0]      rd_addr,
    input  logic [NRD*DATA_W-1:0]  rf_rdata,
    output logic [NRD*DATA_W-1:0]  rd_data,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD*AW-1:0]     fwd_addr,
    input  logic [NFWD*DATA_W-1:0] fwd_data,
    input  logic                   wb_valid,
    input  logic [AW-1:0]          wb_waddr,
    input  logic [TW-1:0]          wb_tag,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   stallreq,
    output logic                   err
);

    localparam int c_nreg = 1 << AW;

    logic [c_nreg-1:0] r_busy;
    logic [LW-1:0]     r_cnt [c_nreg];
    logic [TW-1:0]     r_tag [c_nreg];
    logic [TW-1:0]     r_tctr;
    logic              r_err;

    logic [NRD-1:0]    w_port_stall;
    logic [NRD-1:0]    w_port_nosrc;
    logic              w_accept;
    logic              w_alloc;
    logic              w_retire;

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_port
            logic [AW-1:0]     w_a;
            logic [DATA_W-1:0] w_data;
            logic              w_hit;

            assign w_a = rd_addr[i*AW +: AW];

            // Walk sources oldest-first so the youngest matching one overrides.
            always_comb begin
                w_data = rf_rdata[i*DATA_W +: DATA_W];
                w_hit  = 1'b0;
                if (wb_valid && (wb_waddr == w_a)) begin
                    w_data = wb_data;
                    w_hit  = 1'b1;
                end
                for (int j = NFWD - 1; j >= 0; j--) begin
                    if (fwd_valid[j] && (fwd_addr[j*AW +: AW] == w_a)) begin
                        w_data = fwd_data[j*DATA_W +: DATA_W];
                        w_hit  = 1'b1;
                    end
                end
                if (w_a == '0) begin
                    w_data = '0;
                end
            end

            assign rd_data[i*DATA_W +: DATA_W] = w_data;
            assign w_port_stall[i] = (w_a != '0) && r_busy[w_a] && (r_cnt[w_a] != '0);
            assign w_port_nosrc[i] = (w_a != '0) && r_busy[w_a] && (r_cnt[w_a] == '0) && !w_hit;
        end
    endgenerate

    assign stallreq = |w_port_stall;
    assign iss_tag  = r_tctr;
    assign err      = r_err;

    assign w_accept = iss_valid && !stallreq && !flush;
    assign w_alloc  = w_accept && iss_we && (iss_waddr != '0);
    // A stale tag means a younger writer owns the register; ignore the retire.
    assign w_retire = wb_valid && r_busy[wb_waddr] && (r_tag[wb_waddr] == wb_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_tctr <= '0;
            r_err  <= 1'b0;
            for (int r = 0; r < c_nreg; r++) begin
                r_cnt[r] <= '0;
                r_tag[r] <= '0;
            end
        end else begin
            if (|w_port_nosrc) begin
                r_err <= 1'b1;
            end
            if (flush) begin
                r_busy <= '0;
                for (int r = 0; r < c_nreg; r++) begin
                    r_cnt[r] <= '0;
                end
            end else begin
                for (int r = 0; r < c_nreg; r++) begin
                    if (w_alloc && (iss_waddr == AW'(r))) begin
                        r_busy[r] <= 1'b1;
                        r_cnt[r]  <= iss_lat;
                        r_tag[r]  <= r_tctr;
                    end else if (w_retire && (wb_waddr == AW'(r))) begin
                        r_busy[r] <= 1'b0;
                        r_cnt[r]  <= '0;
                    end else if (r_busy[r] && (r_cnt[r] != '0)) begin
                        r_cnt[r] <= r_cnt[r] - LW'(1);
                    end
                end
                if (w_alloc) begin
                    r_tctr <= r_tctr + TW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_scoreboard
// Purpose  : Directed plus randomized scoreboard bench for id_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_scoreboard;

    localparam int DATA_W = 32;
    localparam int AW     = 5;
    localparam int NRD    = 2;
    localparam int NFWD   = 3;
    localparam int LW     = 3;
    localparam int TW     = 3;
    localparam int c_nreg = 1 << AW;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   iss_valid;
    logic                   iss_we;
    logic [AW-1:0]          iss_waddr;
    logic [LW-1:0]          iss_lat;
    logic [TW-1:0]          iss_tag;
    logic [NRD*AW-1:0]      rd_addr;
    logic [NRD*DATA_W-1:0]  rf_rdata;
    logic [NRD*DATA_W-1:0]  rd_data;
    logic [NFWD-1:0]        fwd_valid;
    logic [NFWD*AW-1:0]     fwd_addr;
    logic [NFWD*DATA_W-1:0] fwd_data;
    logic                   wb_valid;
    logic [AW-1:0]          wb_waddr;
    logic [TW-1:0]          wb_tag;
    logic [DATA_W-1:0]      wb_data;
    logic                   stallreq;
    logic                   err;

    always #5 clk = ~clk;

    id_scoreboard #(
        .DATA_W(DATA_W), .AW(AW), .NRD(NRD), .NFWD(NFWD), .LW(LW), .TW(TW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_we(iss_we), .iss_waddr(iss_waddr),
        .iss_lat(iss_lat), .iss_tag(iss_tag),
        .rd_addr(rd_addr), .rf_rdata(rf_rdata), .rd_data(rd_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_tag(wb_tag),
        .wb_data(wb_data), .stallreq(stallreq), .err(err)
    );

    // Reference model: a register is busy until an absolute ready cycle.
    bit     m_busy  [c_nreg];
    longint m_ready [c_nreg];
    int     m_tag   [c_nreg];
    int     m_tctr;
    bit     m_err;
    longint cyc;

    typedef struct {
        longint                cyc;
        logic                  stall;
        logic [TW-1:0]         tag;
        logic                  err;
        logic [NRD*DATA_W-1:0] rd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic model_clear();
        for (int r = 0; r < c_nreg; r++) begin
            m_busy[r] = 0;
            m_ready[r] = 0;
            m_tag[r] = 0;
        end
        m_tctr = 0;
        m_err = 0;
    endtask

    task automatic idle();
        rst = 0; flush = 0; iss_valid = 0; iss_we = 0; iss_waddr = '0; iss_lat = '0;
        rd_addr = '0; rf_rdata = '0; fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
        wb_valid = 0; wb_waddr = '0; wb_tag = '0; wb_data = '0;
    endtask

    // Compute this cycle's expected outputs, queue them, then advance the model.
    task automatic go();
        exp_t          e;
        bit            nosrc;
        bit            acc;
        bit            found;
        logic [AW-1:0] a;
        logic [DATA_W-1:0] v;
        e.cyc = cyc;
        e.stall = 0;
        e.tag = TW'(m_tctr);
        e.err = m_err;
        e.rd = '0;
        nosrc = 0;
        for (int p = 0; p < NRD; p++) begin
            a = rd_addr[p*AW +: AW];
            if (a != 0 && m_busy[a] && cyc < m_ready[a]) e.stall = 1;
            found = 0;
            v = rf_rdata[p*DATA_W +: DATA_W];
            for (int j = 0; j < NFWD; j++) begin
                if (!found && fwd_valid[j] && fwd_addr[j*AW +: AW] == a) begin
                    v = fwd_data[j*DATA_W +: DATA_W];
                    found = 1;
                end
            end
            if (!found && wb_valid && wb_waddr == a) begin
                v = wb_data;
                found = 1;
            end
            if (a == 0) v = '0;
            if (a != 0 && m_busy[a] && cyc >= m_ready[a] && !found) nosrc = 1;
            e.rd[p*DATA_W +: DATA_W] = v;
        end
        q.push_back(e);

        if (rst) begin
            model_clear();
        end else begin
            if (nosrc) m_err = 1;
            if (flush) begin
                for (int r = 0; r < c_nreg; r++) m_busy[r] = 0;
            end else begin
                acc = iss_valid && !e.stall;
                if (wb_valid && m_busy[wb_waddr] && m_tag[wb_waddr] == int'(wb_tag)
                    && !(acc && iss_we && iss_waddr == wb_waddr))
                    m_busy[wb_waddr] = 0;
                if (acc && iss_we && iss_waddr != 0) begin
                    m_busy[iss_waddr]  = 1;
                    m_ready[iss_waddr] = cyc + 1 + longint'(iss_lat);
                    m_tag[iss_waddr]   = m_tctr;
                    m_tctr = (m_tctr + 1) % (1 << TW);
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic issue(input int r, input int lat);
        iss_valid = 1; iss_we = 1; iss_waddr = AW'(r); iss_lat = LW'(lat);
    endtask

    task automatic set_fwd(input int j, input int r, input logic [DATA_W-1:0] d);
        fwd_valid[j] = 1;
        fwd_addr[j*AW +: AW] = AW'(r);
        fwd_data[j*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        idle(); rst = 1; go(); idle();
    endtask

    task automatic chk(input string nm, input longint c, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, c, act, exp);
        end
    endtask

    // Monitor: compare every queued expectation shortly after inputs settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stallreq", e.cyc, DATA_W'(stallreq), DATA_W'(e.stall));
                chk("iss_tag", e.cyc, DATA_W'(iss_tag), DATA_W'(e.tag));
                chk("err", e.cyc, DATA_W'(err), DATA_W'(e.err));
                for (int p = 0; p < NRD; p++)
                    chk($sformatf("rd_data[%0d]", p), e.cyc,
                        rd_data[p*DATA_W +: DATA_W], e.rd[p*DATA_W +: DATA_W]);
            end
        end
    end

    initial begin
        int pick;
        cyc = 0;
        idle();
        rst = 1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        idle();

        // Lat-0 producer forwarded from the youngest source.
        issue(5, 0); go(); idle();
        rd_addr[0 +: AW] = 5; set_fwd(0, 5, 32'hAAAA); go(); idle();
        wb_valid = 1; wb_waddr = 5; wb_tag = 0; go(); idle();

        // Load-use stall with a held issue.
        do_reset();
        issue(7, 2); go(); idle();
        for (int k = 0; k < 3; k++) begin
            issue(1, 0); rd_addr[0 +: AW] = 7; set_fwd(1, 7, 32'h77); go();
        end
        idle(); go();

        // WAW: stale tag must not retire; reading with no source exposes busy.
        do_reset();
        issue(3, 0); go(); issue(3, 0); go(); idle();
        wb_valid = 1; wb_waddr = 3; wb_tag = 0; go(); idle();
        rd_addr[0 +: AW] = 3; go(); idle(); go();
        do_reset();
        issue(3, 0); go(); issue(3, 0); go(); idle();
        wb_valid = 1; wb_waddr = 3; wb_tag = 1; go(); idle();
        rd_addr[0 +: AW] = 3; go(); idle(); go();

        // Bypass priority.
        do_reset();
        issue(9, 0); go(); idle();
        rd_addr = {AW'(9), AW'(9)};
        rf_rdata = {32'h55, 32'h44};
        set_fwd(0, 9, 32'h11); set_fwd(1, 9, 32'h22);
        wb_valid = 1; wb_waddr = 9; wb_tag = 7; wb_data = 32'h33;
        go();
        fwd_valid[0] = 0; go();
        fwd_valid[1] = 0; go();
        wb_valid = 0; go(); idle();

        // Flush drops a long-latency producer but keeps the tag counter.
        do_reset();
        issue(4, 6); go(); idle();
        flush = 1; issue(6, 1); go(); idle();
        rd_addr[0 +: AW] = 4; go(); idle();

        // Register 0 and the sticky error.
        do_reset();
        issue(0, 3); go(); idle();
        rd_addr[AW +: AW] = 0; rf_rdata = {32'hDEAD, 32'hBEEF}; go(); idle();
        issue(2, 0); go(); idle();
        rd_addr[AW +: AW] = 2; go(); idle();
        go(); go(); go();
        do_reset(); go();

        // Randomized traffic over a mostly small register window.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 29) == 0);
            iss_valid = $urandom_range(0, 1);
            iss_we = ($urandom_range(0, 3) != 0);
            iss_waddr = AW'($urandom_range(0, 3) != 0 ? $urandom_range(0, 7) : $urandom);
            iss_lat = LW'($urandom_range(0, 2) != 0 ? $urandom_range(0, 2) : $urandom_range(0, 7));
            for (int p = 0; p < NRD; p++) begin
                rd_addr[p*AW +: AW] = AW'($urandom_range(0, 3) != 0 ? $urandom_range(0, 7) : $urandom);
                rf_rdata[p*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            for (int j = 0; j < NFWD; j++) begin
                fwd_valid[j] = ($urandom_range(0, 2) == 0);
                fwd_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
                fwd_data[j*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            wb_valid = ($urandom_range(0, 1) == 0);
            pick = $urandom_range(0, 7);
            wb_waddr = AW'(pick);
            wb_tag = ($urandom_range(0, 3) != 0) ? TW'(m_tag[pick]) : TW'($urandom);
            wb_data = DATA_W'($urandom);
            go();
        end

        idle();
        go();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
